// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the vector pipeline controller
package riscv_pkg;

  localparam int PIPE_NUM_STAGES = 5;
  localparam int MC_CNT_WIDTH    = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/riscv_v_mc_counter.sv
// rtl/riscv_v_mc_counter.sv - down-counter for the remaining multi-cycle hold length
module riscv_v_mc_counter #(
  parameter int WIDTH = riscv_pkg::MC_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             cnt_is_one
);

  logic [WIDTH-1:0] cnt;

  // Clear beats load so a flushed operation cannot restart in the same edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign cnt_is_one = (cnt == WIDTH'(1));

endmodule

// File: rtl/riscv_v_pipe_ctrl.sv
// rtl/riscv_v_pipe_ctrl.sv - stall/flush/valid control for an in-order pipeline with a multi-cycle stage
module riscv_v_pipe_ctrl #(
  parameter int NUM_STAGES     = riscv_pkg::PIPE_NUM_STAGES,
  parameter int MC_STAGE       = 2,
  parameter int REDIRECT_STAGE = 2,
  parameter int MC_CNT_WIDTH   = riscv_pkg::MC_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_valid,
  input  logic [NUM_STAGES-1:0]   stall_req,
  input  logic                    redirect,
  input  logic                    mc_req,
  input  logic [MC_CNT_WIDTH-1:0] mc_cycles,
  output logic [NUM_STAGES-1:0]   stage_en,
  output logic [NUM_STAGES-1:0]   stage_flush,
  output logic [NUM_STAGES-1:0]   stage_valid,
  output logic                    fetch_ready,
  output logic                    retire_valid,
  output logic                    mc_busy,
  output logic [15:0]             stall_cnt
);

  import riscv_pkg::*;

  pipe_state_t               state;
  logic                      mc_busy_q;
  logic [NUM_STAGES-1:0]     valid_q;
  logic [NUM_STAGES-1:0]     hold;
  logic [NUM_STAGES-1:0]     flush_raw;
  logic [NUM_STAGES-1:0]     capture;
  logic [15:0]               stall_cnt_q;
  logic                      redirect_q;
  logic                      mc_start;
  logic                      mc_hold;
  logic                      mc_flush;
  logic                      cnt_is_one;
  logic [MC_CNT_WIDTH-1:0]   mc_len;

  assign redirect_q = redirect & valid_q[REDIRECT_STAGE];
  assign mc_start   = (state == RUN) & mc_req & valid_q[MC_STAGE];
  assign mc_hold    = mc_start | (state == MC_BUSY);
  assign mc_len     = (mc_cycles == '0) ? MC_CNT_WIDTH'(1) : mc_cycles;

  // Back-pressure ripples downward only through occupied stages, so bubbles collapse.
  always_comb begin
    logic chain;
    hold  = '0;
    chain = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      hold[i] = valid_q[i] & (stall_req[i] | (mc_hold & (i == MC_STAGE)) | chain);
      chain   = hold[i];
    end
  end

  always_comb begin
    flush_raw = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i < REDIRECT_STAGE) begin
        flush_raw[i] = redirect_q;
      end
    end
  end

  assign capture  = {valid_q[NUM_STAGES-2:0] & ~hold[NUM_STAGES-2:0], fetch_valid};
  assign mc_flush = flush_raw[MC_STAGE];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= ~flush_raw & ((hold & valid_q) | (~hold & capture));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || mc_flush) begin
      state     <= RUN;
      mc_busy_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mc_start) begin
            state     <= MC_BUSY;
            mc_busy_q <= 1'b1;
          end
        end
        MC_BUSY: begin
          if (cnt_is_one) begin
            state <= MC_DONE;
          end
        end
        MC_DONE: begin
          if (!hold[MC_STAGE]) begin
            state     <= RUN;
            mc_busy_q <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          mc_busy_q <= 1'b0;
        end
      endcase
    end
  end

  riscv_v_mc_counter #(.WIDTH(MC_CNT_WIDTH)) u_mc_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (mc_start & ~mc_flush),
    .load_val   (mc_len),
    .dec        ((state == MC_BUSY) & ~mc_flush),
    .clr        (mc_flush),
    .cnt_is_one (cnt_is_one)
  );

  // Outside reset, fetch_ready is low exactly when stage 0 holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hold[0] && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stage_en     = rst ? '0 : ~hold;
  assign stage_flush  = rst ? '1 : flush_raw;
  assign stage_valid  = valid_q;
  assign fetch_ready  = ~rst & ~hold[0];
  assign retire_valid = ~rst & valid_q[NUM_STAGES-1] & ~hold[NUM_STAGES-1];
  assign mc_busy      = mc_busy_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/riscv_v_pipe_ctrl.md
RISCV_V_PIPE_CTRL -- requirements
Module: riscv_v_pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5: number of pipeline stage registers controlled (>=2).
REQ-002 SHALL have parameter MC_STAGE, default 2: index of the stage hosting multi-cycle operations.
REQ-003 SHALL have parameter REDIRECT_STAGE, default 2: index of the stage that raises redirect.
REQ-004 SHALL have parameter MC_CNT_WIDTH, default 4: width of the multi-cycle length field.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port fetch_valid  input  1  new instruction offered to stage 0.
REQ-008 SHALL have port stall_req  input  NUM_STAGES  per-stage "cannot advance" request.
REQ-009 SHALL have port redirect  input  1  taken branch or exception from REDIRECT_STAGE.
REQ-010 SHALL have port mc_req  input  1  instruction in MC_STAGE needs extra cycles.
REQ-011 SHALL have port mc_cycles  input  MC_CNT_WIDTH  number of extra cycles; 0 is treated as 1.
REQ-012 SHALL have port stage_en  output  NUM_STAGES  capture enable for each stage register (stage i captures from i-1; stage 0 captures from fetch).
REQ-013 SHALL have port stage_flush  output  NUM_STAGES  flush strobe for each stage register.
REQ-014 SHALL have port stage_valid  output  NUM_STAGES  registered occupancy bit per stage.
REQ-015 SHALL have port fetch_ready  output  1  stage 0 accepts fetch this cycle.
REQ-016 SHALL have port retire_valid  output  1  last stage retires this cycle.
REQ-017 SHALL have port mc_busy  output  1  multi-cycle FSM is not in RUN.
REQ-018 SHALL have port stall_cnt  output  16  saturating count of cycles with fetch_ready=0.

Function
REQ-019 SHALL compute hold[i] = stage_valid[i] & (stall_req[i] | mc_hold[i] | (i<NUM_STAGES-1 & hold[i+1])), so that an empty stage never holds (bubble collapse).
REQ-020 SHALL drive stage_en[i] = !hold[i], fetch_ready = stage_en[0], and retire_valid = stage_valid[NUM_STAGES-1] & !hold[NUM_STAGES-1].
REQ-021 SHALL qualify redirect as redirect & stage_valid[REDIRECT_STAGE]; when qualified, stage_flush[i]=1 for every i<REDIRECT_STAGE, and all other stage_flush bits=0.
REQ-022 SHALL update stage_valid[i] with priority flush > en: 0 when flushed; else valid[i-1]&!hold[i-1] (fetch_valid for i=0) when enabled; else unchanged.
REQ-023 SHALL implement FSM states RUN, MC_BUSY and MC_DONE.
REQ-024 SHALL, in RUN with mc_req & stage_valid[MC_STAGE], assert mc_hold[MC_STAGE] that cycle, load cnt with max(mc_cycles,1), and go to MC_BUSY.
REQ-025 SHALL, in MC_BUSY, assert mc_hold[MC_STAGE], decrement cnt each cycle, and go to MC_DONE on the cycle cnt==1.
REQ-026 SHALL, in MC_DONE, ignore mc_req and deassert mc_hold; return to RUN when stage_en[MC_STAGE]=1, otherwise stay in MC_DONE.
REQ-027 SHALL give a total MC_STAGE hold of 1+max(mc_cycles,1) cycles when no other stall is present.
REQ-028 SHALL, when a qualified redirect flushes MC_STAGE (MC_STAGE<REDIRECT_STAGE) in any state, go to RUN and clear cnt in the same edge.
REQ-029 SHALL increment stall_cnt on every cycle with fetch_ready=0 and saturate at 0xFFFF.
REQ-030 SHALL allow redirect and stall_req in the same cycle: flush wins for flushed stages, and hold applies to the rest.

Reset
REQ-031 SHALL, while rst=1, force at the next edge: stage_valid=0, FSM=RUN, cnt=0, stall_cnt=0.
REQ-032 SHALL, while rst=1, drive stage_en=0, stage_flush=all ones, retire_valid=0 and fetch_ready=0, and SHALL not count those cycles in stall_cnt.
REQ-033 SHALL abort any multi-cycle operation when reset is applied mid-operation, with no residual hold after rst falls.

Structure
REQ-034 SHALL place the pipe_state_t enum (RUN, MC_BUSY, MC_DONE), PIPE_NUM_STAGES and MC_CNT_WIDTH in riscv_pkg.
REQ-035 SHALL contain the single sub-module riscv_v_mc_counter (load/decrement/clear, outputs cnt==1), with all other logic inline.

Verification
REQ-036 Free flow: fetch_valid=1 for 10 cycles, no stalls -> first retire_valid 5 cycles later, then 10 consecutive retires, stall_cnt=0.
REQ-037 Bubble collapse: pipe holding valid=10101, stall_req[4]=1 for 3 cycles -> stage 4 held, stages 3 and 1 keep accepting until valid=11111, fetch_ready=0 only after stage 0 is full.
REQ-038 Multi-cycle: mc_req with mc_cycles=3 at MC_STAGE -> stage_en[2]=0 for 4 cycles, mc_busy high 4 cycles, instruction advances on the 5th cycle; mc_cycles=0 -> hold 2 cycles.
REQ-039 Redirect: stage_valid=11111 and redirect=1 -> stage_flush=00011, next stage_valid=11100 (bit4..0 shown MSB first), stage 2 advances normally.
REQ-040 Reset mid-operation: rst=1 during MC_BUSY with cnt=2 -> after release FSM=RUN, stage_valid=0, no hold on the first fetch.
REQ-041 Saturation: force fetch_ready=0 for 70000 cycles -> stall_cnt=0xFFFF, with no wrap.
